// File: rtl/msi_snoop_ctrl_pkg.sv
// common: shared cache-line state, bus op and snoop FSM types.
package common;
  typedef enum logic [1:0] {INVALID = 2'b00, SHARED = 2'b01, MODIFIED = 2'b10} blk_state_t;
  typedef enum logic [1:0] {NONE = 2'b00, BUS_RD = 2'b01, BUS_RDX = 2'b10, BUS_UPGR = 2'b11} bus_op_t;
  typedef enum logic [2:0] {IDLE, SNOOP, EVAL, WB, MEMRD, UPDATE, RESP} snoop_state_t;
  function automatic logic [1:0] onehot2(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/msi_snoop_ctrl_arb.sv
// rr_arb2: two-way round-robin arbiter; the pointer remembers the core served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o
);
  logic last_q;
  assign gnt_o = (&req_i) ? ~last_q : req_i[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (take_i) last_q <= gnt_o;
endmodule

// File: rtl/msi_snoop_ctrl.sv
// msi_snoop_ctrl: two-core MSI snoop controller, one bus transaction at a time.
module msi_snoop_ctrl
  import common::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [3:0]  req_op,
  input  logic [21:0] req_addr,
  output logic [1:0]  snp_search,
  output logic [10:0] snp_addr,
  input  logic [1:0]  snp_hit,
  input  logic [1:0]  snp_state_0,
  input  logic [1:0]  snp_state_1,
  input  logic [63:0] snp_data_0,
  input  logic [63:0] snp_data_1,
  output logic [1:0]  snp_we,
  output logic [1:0]  snp_wstate,
  output logic [63:0] snp_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [10:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        resp_valid,
  output logic        resp_core,
  output logic [1:0]  resp_state,
  output logic [63:0] resp_data
);
  snoop_state_t state_q, state_d;
  bus_op_t op_q, op_d;
  blk_state_t tst;
  logic core_q, core_d, gnt, thit;
  logic [10:0] addr_q, addr_d;
  logic [63:0] data_q, data_d, tdata;
  logic [1:0] snp_search_q, snp_we_q, snp_wstate_q, resp_state_q;
  logic [10:0] snp_addr_q, mem_addr_q;
  logic [63:0] snp_wdata_q, mem_wdata_q, resp_data_q;
  logic mem_we_q, mem_re_q, resp_valid_q, resp_core_q;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .take_i (state_q == IDLE && |req),
    .gnt_o  (gnt)
  );
  // The target is always the other core's cache.
  assign thit  = core_q ? snp_hit[0] : snp_hit[1];
  assign tst   = blk_state_t'(core_q ? snp_state_0 : snp_state_1);
  assign tdata = core_q ? snp_data_0 : snp_data_1;
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SNOOP;
        core_d  = gnt;
        op_d    = bus_op_t'(gnt ? req_op[3:2] : req_op[1:0]);
        addr_d  = gnt ? req_addr[21:11] : req_addr[10:0];
      end
      SNOOP: state_d = EVAL;
      EVAL: begin
        data_d  = tdata;
        state_d = (thit && tst == MODIFIED) ? WB :
                  (!thit && op_q != BUS_UPGR) ? MEMRD :
                  (thit && op_q != BUS_RD) ? UPDATE : RESP;
      end
      WB: state_d = mem_rdy ? UPDATE : WB;
      MEMRD: if (mem_rdy) begin
        state_d = RESP;
        data_d  = mem_rdata;
      end
      UPDATE: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      core_q  <= 1'b0;
      op_q    <= NONE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snp_search_q <= '0;
      snp_addr_q   <= '0;
      snp_we_q     <= '0;
      snp_wstate_q <= '0;
      snp_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_core_q  <= 1'b0;
      resp_state_q <= '0;
      resp_data_q  <= '0;
    end else begin
      snp_search_q <= (state_d == SNOOP) ? onehot2(!core_d) : 2'b00;
      snp_addr_q   <= (state_d == SNOOP) ? addr_d : '0;
      snp_we_q     <= (state_d == UPDATE) ? onehot2(!core_d) : 2'b00;
      snp_wstate_q <= (state_d == UPDATE && op_d == BUS_RD) ? SHARED : INVALID;
      snp_wdata_q  <= (state_d == UPDATE) ? data_d : '0;
      mem_we_q     <= state_d == WB;
      mem_re_q     <= state_d == MEMRD;
      mem_addr_q   <= (state_d == WB || state_d == MEMRD) ? addr_d : '0;
      mem_wdata_q  <= (state_d == WB) ? data_d : '0;
      resp_valid_q <= state_d == RESP;
      resp_core_q  <= (state_d == RESP) && core_d;
      resp_state_q <= (state_d != RESP) ? INVALID : (op_d == BUS_RD) ? SHARED : MODIFIED;
      resp_data_q  <= (state_d == RESP && op_d != BUS_UPGR) ? data_d : '0;
    end
  assign snp_search = snp_search_q;
  assign snp_addr   = snp_addr_q;
  assign snp_we     = snp_we_q;
  assign snp_wstate = snp_wstate_q;
  assign snp_wdata  = snp_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_core  = resp_core_q;
  assign resp_state = resp_state_q;
  assign resp_data  = resp_data_q;
endmodule
